// File: rtl/param_core_if.sv
`default_nettype none
// param_core_if: req/ack memory bus between the core (master) and system memory (slave).
// Rev 1.0
interface param_core_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/param_core.sv
`default_nettype none
// param_core: multi-cycle in-order core with flag file and stallable req/ack memory bus.
// Option PARAM_CORE_RETIRE_CNT_EN adds the 32-bit retired-instruction counter. Rev 1.0
module param_core #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 8,
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clock,
  input  wire logic              reset,
  param_core_if.master           bus,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted
`ifdef PARAM_CORE_RETIRE_CNT_EN
  ,
  output logic [31:0]            retired
`endif
);
  localparam int RW = $clog2(NREGS);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_LDI  = 6'd5;
  localparam logic [5:0] OP_LD   = 6'd6;
  localparam logic [5:0] OP_ST   = 6'd7;
  localparam logic [5:0] OP_EQ   = 6'd8;
  localparam logic [5:0] OP_LTU  = 6'd9;
  localparam logic [5:0] OP_JMP  = 6'd10;
  localparam logic [5:0] OP_JF   = 6'd11;
  localparam logic [5:0] OP_FNOT = 6'd12;
  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state;
  logic [63:0]       instr;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  flags;

  logic [5:0]        op;
  logic [RW-1:0]     ra, rb, rd;
  logic              hl;
  logic [31:0]       imm;
  logic [DATA_W-1:0] opa, opb, dcur, ldi_hi, alu_res;
  logic              unused_bits;

  assign op   = instr[5:0];
  assign ra   = instr[6 +: RW];
  assign rb   = instr[9 +: RW];
  assign rd   = instr[12 +: RW];
  assign hl   = instr[15];
  assign imm  = instr[63:32];
  assign opa  = regs[ra];
  assign opb  = regs[rb];
  assign dcur = regs[rd];

  assign unused_bits = ^{instr[31:6], dcur, bus.mem_rdata};

  // High-half load only exists when the register is wider than 32 bits.
  generate
    if (DATA_W > 32) begin : g_ldi_hi
      assign ldi_hi = {imm[DATA_W-33:0], dcur[31:0]};
    end else begin : g_ldi_keep
      assign ldi_hi = dcur;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_LDI:  alu_res = hl ? ldi_hi : DATA_W'(imm);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags         <= '0;
      instr         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      halted        <= 1'b0;
`ifdef PARAM_CORE_RETIRE_CNT_EN
      retired       <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          // An idle cycle with req low always precedes each new request.
          if (!bus.mem_req) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= pc;
          end else if (bus.mem_ack) begin
            instr       <= bus.mem_rdata;
            pc          <= pc + ADDR_W'(1);
            bus.mem_req <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
`ifdef PARAM_CORE_RETIRE_CNT_EN
          if (op != OP_LD && op != OP_ST) retired <= retired + 32'd1;
`endif
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: regs[rd] <= alu_res;
            OP_LD, OP_ST: begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= (op == OP_ST);
              bus.mem_addr  <= ADDR_W'(opa);
              if (op == OP_ST) bus.mem_wdata <= opb;
              state         <= S_MEM;
            end
            OP_EQ:   flags[rd] <= (opa == opb);
            OP_LTU:  flags[rd] <= (opa < opb);
            OP_JMP:  pc <= ADDR_W'(opa);
            OP_JF:   if (flags[ra]) pc <= ADDR_W'(imm);
            OP_FNOT: flags[rd] <= ~flags[ra];
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (!bus.mem_we) regs[rd] <= bus.mem_rdata[DATA_W-1:0];
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= S_FETCH;
`ifdef PARAM_CORE_RETIRE_CNT_EN
            retired     <= retired + 32'd1;
`endif
          end
        end
        S_HALT: begin
          halted      <= 1'b1;
          bus.mem_req <= 1'b0;
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule
`default_nettype wire
